// File: rtl/gerador_mensagem.sv
// Message sequencer: streams one character per step from a constant message table,
// stepping on the consumer handshake or on an internal dwell timer, with optional looping.
module gerador_mensagem #(
  parameter int CHAR_WIDTH = 4,
  parameter int MAX_LEN    = 8,
  parameter int NUM_MSG    = 4,
  parameter int IDX_W      = $clog2(MAX_LEN),
  parameter int LEN_W      = $clog2(MAX_LEN + 1),
  parameter int SEL_W      = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1,
  parameter logic [NUM_MSG*MAX_LEN*CHAR_WIDTH-1:0] MSG_ROM =
    128'h00000000_00000000_00000017_007A4310,
  parameter logic [NUM_MSG*LEN_W-1:0] LEN_ROM = 16'h0036,
  parameter int DWELL      = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [SEL_W-1:0]      msg_sel,
  input  logic                  auto_mode,
  input  logic                  loop_en,
  input  logic                  advance,
  input  logic                  stop,
  output logic [CHAR_WIDTH-1:0] caracter,
  output logic [IDX_W-1:0]      counter_caracter,
  output logic [LEN_W-1:0]      len_string,
  output logic                  valid,
  output logic                  busy,
  output logic                  wrap,
  output logic                  done
);

  // state | meaning
  // IDLE  | waiting for start, outputs quiet
  // SHOW  | presenting table[msg][counter_caracter]
  // FIM   | one-cycle completion pulse, then IDLE
  typedef enum logic [1:0] {IDLE, SHOW, FIM} state_t;

  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  state_t           state;
  logic [SEL_W-1:0] sel_q;
  logic             auto_q;
  logic             loop_q;
  logic [DW_W-1:0]  dwell_cnt;
  logic             step;
  logic             last;

  function automatic logic [CHAR_WIDTH-1:0] char_at(input logic [SEL_W-1:0] sel,
                                                    input logic [IDX_W-1:0] idx);
    char_at = '0;
    if (int'(sel) < NUM_MSG)
      char_at = MSG_ROM[(int'(sel)*MAX_LEN + int'(idx))*CHAR_WIDTH +: CHAR_WIDTH];
  endfunction

  function automatic logic [LEN_W-1:0] eff_len(input logic [SEL_W-1:0] sel);
    logic [LEN_W-1:0] l;
    eff_len = '0;
    if (int'(sel) < NUM_MSG) begin
      l = LEN_ROM[int'(sel)*LEN_W +: LEN_W];
      eff_len = (int'(l) > MAX_LEN) ? LEN_W'(MAX_LEN) : l;
    end
  endfunction

  assign step = auto_q ? (dwell_cnt == DW_W'(DWELL - 1)) : advance;
  assign last = (int'(counter_caracter) >= int'(len_string) - 1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= IDLE;
      sel_q            <= '0;
      auto_q           <= 1'b0;
      loop_q           <= 1'b0;
      dwell_cnt        <= '0;
      caracter         <= '0;
      counter_caracter <= '0;
      len_string       <= '0;
      valid            <= 1'b0;
      busy             <= 1'b0;
      wrap             <= 1'b0;
      done             <= 1'b0;
    end else begin
      wrap <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          valid <= 1'b0;
          busy  <= 1'b0;
          if (start) begin
            sel_q            <= msg_sel;
            auto_q           <= auto_mode;
            loop_q           <= loop_en;
            len_string       <= eff_len(msg_sel);
            counter_caracter <= '0;
            dwell_cnt        <= '0;
            busy             <= 1'b1;
            if (eff_len(msg_sel) != '0) begin
              state    <= SHOW;
              valid    <= 1'b1;
              caracter <= char_at(msg_sel, '0);
            end else begin
              state <= FIM;
              done  <= 1'b1;
            end
          end
        end
        SHOW: begin
          if (stop) begin
            state <= IDLE;
            valid <= 1'b0;
            busy  <= 1'b0;
          end else begin
            if (auto_q)
              dwell_cnt <= step ? '0 : dwell_cnt + 1'b1;
            if (step) begin
              if (!last) begin
                counter_caracter <= counter_caracter + 1'b1;
                caracter         <= char_at(sel_q, counter_caracter + 1'b1);
              end else if (loop_q) begin
                counter_caracter <= '0;
                caracter         <= char_at(sel_q, '0);
                wrap             <= 1'b1;
              end else begin
                state <= FIM;
                valid <= 1'b0;
                done  <= 1'b1;
              end
            end
          end
        end
        FIM: begin
          state <= IDLE;
          valid <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          valid <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gerador_mensagem.sv
// Directed bench for gerador_mensagem: manual, auto, loop, zero/clamped length,
// ignored inputs, back-to-back start and mid-message reset.
module tb_gerador_mensagem;

  logic       clock = 1'b0;
  logic       reset, start, auto_mode, loop_en, advance, stop;
  logic [1:0] msg_sel;
  logic [3:0] caracter;
  logic [2:0] counter_caracter;
  logic [3:0] len_string;
  logic       valid, busy, wrap, done;

  int n_cmp = 0;
  int n_bad = 0;

  // msg 3 is given a raw length of 12 to exercise the clamp to MAX_LEN
  gerador_mensagem #(
    .CHAR_WIDTH(4), .MAX_LEN(8), .NUM_MSG(4),
    .LEN_ROM(16'hC036), .DWELL(3)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .msg_sel(msg_sel),
    .auto_mode(auto_mode), .loop_en(loop_en), .advance(advance), .stop(stop),
    .caracter(caracter), .counter_caracter(counter_caracter),
    .len_string(len_string), .valid(valid), .busy(busy), .wrap(wrap), .done(done)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 0; msg_sel = 0; auto_mode = 0; loop_en = 0; advance = 0; stop = 0;
    tick(); tick();
    reset = 1'b0;
    n_cmp++;
    if ({caracter, counter_caracter, len_string, valid, busy, wrap, done} !== 15'd0) begin
      n_bad++;
      $display("FAIL reset_state: got %h expected 0",
               {caracter, counter_caracter, len_string, valid, busy, wrap, done});
    end
  endtask

  task automatic test_manual_and_back_to_back();
    logic [3:0] exp_c [6] = '{4'h0, 4'h1, 4'h3, 4'h4, 4'hA, 4'h7};
    start = 1; msg_sel = 0; auto_mode = 0; loop_en = 0;
    tick();
    start = 0; advance = 1;
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (caracter !== exp_c[i] || counter_caracter !== 3'(i) || len_string !== 4'd6 ||
          valid !== 1'b1 || busy !== 1'b1 || wrap !== 1'b0 || done !== 1'b0) begin
        n_bad++;
        $display("FAIL manual_char%0d: got c=%h idx=%0d len=%0d v=%b b=%b w=%b d=%b expected c=%h idx=%0d len=6 v=1 b=1 w=0 d=0",
                 i, caracter, counter_caracter, len_string, valid, busy, wrap, done, exp_c[i], i);
      end
      tick();
    end
    advance = 0;
    n_cmp++;
    if (done !== 1'b1 || valid !== 1'b0 || busy !== 1'b1 || counter_caracter !== 3'd5 || len_string !== 4'd6) begin
      n_bad++;
      $display("FAIL manual_done: got d=%b v=%b b=%b idx=%0d len=%0d expected d=1 v=0 b=1 idx=5 len=6",
               done, valid, busy, counter_caracter, len_string);
    end
    start = 1; msg_sel = 1;
    tick();
    n_cmp++;
    if (done !== 1'b0 || valid !== 1'b0 || busy !== 1'b0 || counter_caracter !== 3'd5) begin
      n_bad++;
      $display("FAIL start_in_fim_ignored: got d=%b v=%b b=%b idx=%0d expected d=0 v=0 b=0 idx=5",
               done, valid, busy, counter_caracter);
    end
    tick();
    start = 0;
    n_cmp++;
    if (valid !== 1'b1 || caracter !== 4'h7 || counter_caracter !== 3'd0 || len_string !== 4'd3) begin
      n_bad++;
      $display("FAIL back_to_back_start: got v=%b c=%h idx=%0d len=%0d expected v=1 c=7 idx=0 len=3",
               valid, caracter, counter_caracter, len_string);
    end
    stop = 1;
    tick();
    stop = 0;
  endtask

  task automatic test_auto();
    logic [3:0] exp_c [3] = '{4'h7, 4'h1, 4'h0};
    start = 1; msg_sel = 1; auto_mode = 1; loop_en = 0;
    tick();
    start = 0; auto_mode = 0;
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (caracter !== exp_c[i] || counter_caracter !== 3'(i) || valid !== 1'b1 || done !== 1'b0) begin
          n_bad++;
          $display("FAIL auto_char%0d_cycle%0d: got c=%h idx=%0d v=%b d=%b expected c=%h idx=%0d v=1 d=0",
                   i, k, caracter, counter_caracter, valid, done, exp_c[i], i);
        end
        tick();
      end
    end
    n_cmp++;
    if (done !== 1'b1 || valid !== 1'b0) begin
      n_bad++;
      $display("FAIL auto_done: got d=%b v=%b expected d=1 v=0", done, valid);
    end
    tick();
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL auto_idle_after: got b=%b d=%b expected b=0 d=0", busy, done);
    end
  endtask

  task automatic test_loop_and_stop();
    logic [3:0] exp_c [3] = '{4'h7, 4'h1, 4'h0};
    start = 1; msg_sel = 1; auto_mode = 0; loop_en = 1;
    tick();
    start = 0; loop_en = 0; advance = 1;
    for (int i = 0; i < 7; i++) begin
      n_cmp++;
      if (caracter !== exp_c[i % 3] || counter_caracter !== 3'(i % 3) ||
          wrap !== ((i == 3 || i == 6) ? 1'b1 : 1'b0) || done !== 1'b0 || valid !== 1'b1) begin
        n_bad++;
        $display("FAIL loop_step%0d: got c=%h idx=%0d w=%b d=%b v=%b expected c=%h idx=%0d w=%b d=0 v=1",
                 i, caracter, counter_caracter, wrap, done, valid, exp_c[i % 3], i % 3,
                 (i == 3 || i == 6));
      end
      if (i < 6) tick();
    end
    stop = 1;
    tick();
    stop = 0; advance = 0;
    n_cmp++;
    if (valid !== 1'b0 || done !== 1'b0 || wrap !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL stop_beats_advance: got v=%b d=%b w=%b b=%b expected all 0", valid, done, wrap, busy);
    end
    tick();
    n_cmp++;
    if (done !== 1'b0 || valid !== 1'b0) begin
      n_bad++;
      $display("FAIL stop_no_late_done: got d=%b v=%b expected 0 0", done, valid);
    end
  endtask

  task automatic test_lengths();
    start = 1; msg_sel = 2;
    tick();
    start = 0;
    n_cmp++;
    if (done !== 1'b1 || valid !== 1'b0 || len_string !== 4'd0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL zero_len_done: got d=%b v=%b len=%0d b=%b expected d=1 v=0 len=0 b=1",
               done, valid, len_string, busy);
    end
    tick();
    n_cmp++;
    if (done !== 1'b0 || valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_len_after: got d=%b v=%b b=%b expected 0 0 0", done, valid, busy);
    end
    start = 1; msg_sel = 3;
    tick();
    start = 0;
    n_cmp++;
    if (len_string !== 4'd8 || valid !== 1'b1 || counter_caracter !== 3'd0 || caracter !== 4'h0) begin
      n_bad++;
      $display("FAIL clamped_len: got len=%0d v=%b idx=%0d c=%h expected len=8 v=1 idx=0 c=0",
               len_string, valid, counter_caracter, caracter);
    end
    stop = 1;
    tick();
    stop = 0;
  endtask

  task automatic test_ignored();
    start = 1; msg_sel = 0; auto_mode = 0;
    tick();
    msg_sel = 1;
    tick();
    start = 0;
    n_cmp++;
    if (caracter !== 4'h0 || counter_caracter !== 3'd0 || len_string !== 4'd6 || valid !== 1'b1) begin
      n_bad++;
      $display("FAIL start_in_show_ignored: got c=%h idx=%0d len=%0d v=%b expected c=0 idx=0 len=6 v=1",
               caracter, counter_caracter, len_string, valid);
    end
    advance = 1;
    tick();
    advance = 0;
    n_cmp++;
    if (caracter !== 4'h1 || counter_caracter !== 3'd1) begin
      n_bad++;
      $display("FAIL manual_single_advance: got c=%h idx=%0d expected c=1 idx=1", caracter, counter_caracter);
    end
    stop = 1;
    tick();
    stop = 0;
    start = 1; msg_sel = 1; auto_mode = 1;
    tick();
    start = 0; auto_mode = 0; advance = 1;
    tick(); tick();
    n_cmp++;
    if (caracter !== 4'h7 || counter_caracter !== 3'd0) begin
      n_bad++;
      $display("FAIL advance_in_auto_ignored: got c=%h idx=%0d expected c=7 idx=0", caracter, counter_caracter);
    end
    tick();
    advance = 0;
    n_cmp++;
    if (caracter !== 4'h1 || counter_caracter !== 3'd1) begin
      n_bad++;
      $display("FAIL auto_dwell_step: got c=%h idx=%0d expected c=1 idx=1", caracter, counter_caracter);
    end
    stop = 1;
    tick();
    stop = 0;
  endtask

  task automatic test_reset_mid();
    start = 1; msg_sel = 0; auto_mode = 0;
    tick();
    start = 0; advance = 1;
    tick(); tick(); tick();
    n_cmp++;
    if (caracter !== 4'h4 || counter_caracter !== 3'd3) begin
      n_bad++;
      $display("FAIL pre_reset_index3: got c=%h idx=%0d expected c=4 idx=3", caracter, counter_caracter);
    end
    reset = 1; start = 1; stop = 1;
    tick();
    n_cmp++;
    if ({caracter, counter_caracter, len_string, valid, busy, wrap, done} !== 15'd0) begin
      n_bad++;
      $display("FAIL reset_mid_message: got %h expected 0",
               {caracter, counter_caracter, len_string, valid, busy, wrap, done});
    end
    reset = 0; stop = 0; advance = 0;
    tick();
    start = 0;
    n_cmp++;
    if (caracter !== 4'h0 || counter_caracter !== 3'd0 || valid !== 1'b1 || len_string !== 4'd6) begin
      n_bad++;
      $display("FAIL replay_after_reset: got c=%h idx=%0d v=%b len=%0d expected c=0 idx=0 v=1 len=6",
               caracter, counter_caracter, valid, len_string);
    end
    stop = 1;
    tick();
    stop = 0;
  endtask

  initial begin
    test_reset();
    test_manual_and_back_to_back();
    test_auto();
    test_loop_and_stop();
    test_lengths();
    test_ignored();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gerador_mensagem.md
# gerador_mensagem

Parametrised message sequencer for the character display path. Holds a constant table of up to NUM_MSG messages, each up to MAX_LEN character codes, and streams the selected message one character per step, with a registered position counter and length. Stepping is driven either by a consumer handshake (`advance`) or by an internal dwell timer, with optional looping. Sits between the control FSM, which issues `start` and `msg_sel`, and the display driver, which consumes `caracter` and `counter_caracter`.

## Interface
- CHAR_WIDTH, 4: bits per character code.
- MAX_LEN, 8: max characters per message; IDX_W = clog2(MAX_LEN), LEN_W = clog2(MAX_LEN+1).
- NUM_MSG, 4: number of messages; SEL_W = clog2(NUM_MSG) (min 1).
- MSG_ROM, see Operation: flattened NUM_MSG*MAX_LEN*CHAR_WIDTH bits; char j of msg m at bits [(m*MAX_LEN+j)*CHAR_WIDTH +: CHAR_WIDTH].
- LEN_ROM, see Operation: flattened NUM_MSG*LEN_W bits; length of msg m at [m*LEN_W +: LEN_W].
- DWELL, 16: cycles each character is held in auto mode (>=1).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  begin message; sampled only in IDLE.
- msg_sel  in  SEL_W  message index, latched with `start`.
- auto_mode  in  1  1 = timer stepping, 0 = `advance` stepping; latched with `start`.
- loop_en  in  1  1 = wrap to char 0 after last; latched with `start`.
- advance  in  1  consumer accepts current char (manual mode only).
- stop  in  1  abort current message.
- caracter  out  CHAR_WIDTH  current character code.
- counter_caracter  out  IDX_W  index of current character.
- len_string  out  LEN_W  effective length of active message.
- valid  out  1  `caracter` is meaningful.
- busy  out  1  not in IDLE.
- wrap  out  1  one-cycle pulse on loop wrap.
- done  out  1  one-cycle pulse on normal completion.

## Operation
- Default table: msg 0 = A,C,E,I,T,O = 0x0,0x1,0x3,0x4,0xA,0x7, length 6; msg 1 = O,C,A = 0x7,0x1,0x0, length 3; msgs 2,3 length 0. Unused slots 0.
- Effective length = min(LEN_ROM[m], MAX_LEN); msg_sel >= NUM_MSG gives length 0.
- States: IDLE, SHOW, FIM.
- IDLE: valid=0, busy=0. On `start`, latch msg_sel/auto_mode/loop_en, load len_string, counter_caracter=0, dwell counter=0. Length>0 -> SHOW; length 0 -> FIM.
- SHOW: valid=1, busy=1, caracter = table[msg][counter_caracter]. Step event = `advance` (manual) or dwell counter reaching DWELL-1 (auto; counter resets on each step). On step: if counter_caracter < len-1, increment; else if loop_en, set to 0 and pulse `wrap`; else -> FIM.
- FIM: one cycle, done=1, valid=0; -> IDLE. counter_caracter and len_string hold last values until next `start`.
- `stop` in SHOW or FIM: -> IDLE next cycle, valid=0, no `done`, no `wrap`; `stop` wins over a same-cycle step. `stop` in IDLE ignored.
- `start` outside IDLE ignored; `advance` in auto mode or outside SHOW ignored.

## Timing
- All outputs registered. Reset values: caracter=0, counter_caracter=0, len_string=0, valid=0, busy=0, wrap=0, done=0; state IDLE; latched controls 0.
- `start` at edge N -> valid=1 with char 0 from cycle N+1 (or done=1 in N+1 for length 0).
- Manual: `advance` high at edge K with valid -> next char visible at K+1; `advance` held high steps every cycle.
- Auto: each char visible exactly DWELL cycles; DWELL=1 steps every cycle.
- Last step (no loop) at edge K -> done=1, valid=0 in cycle K+1; IDLE at K+2, `start` accepted from K+2.
- Wrap at edge K -> counter_caracter=0 and wrap=1 in cycle K+1.
- `reset` mid-message returns all outputs to reset values next cycle, overriding every input.

## Test plan
- Reset, then start msg_sel=0, manual, advance every cycle -> caracter 0,1,3,4,A,7 with counter_caracter 0..5, len_string=6, done pulses one cycle after sixth char, no wrap.
- msg_sel=1, auto_mode=1, DWELL=3 -> 7,1,0 each held exactly 3 cycles, then done pulse; busy low afterwards.
- msg_sel=1, loop_en=1, manual -> 7,1,0,7,1,... with wrap=1 aligned with each return to index 0, no done; `stop` -> valid=0 next cycle, no done.
- msg_sel=2 (length 0) -> done=1 one cycle after start, valid never high; LEN_ROM entry 12 with MAX_LEN=8 -> len_string=8.
- `start` during SHOW, `advance` in auto mode, simultaneous `stop`+`advance` -> ignored / ignored / stop wins, no done.
- `reset` asserted at index 3 of msg 0 -> all outputs 0 next cycle; subsequent start replays from index 0.
